can_error_frame: RTL and testbench

Error-frame generator and bus-off recovery sequencer for the CAN controller. Sits directly downstream of `can_error_handling`:
- Consumes its per-bit error strobes and its `error_passive` / `bus_off` state.
- Drives the active or passive error flag and the 8-bit error delimiter onto the transmit path.
- Returns the `dominant_after_flag` strobe that `can_error_handling` uses for its REC +8 rule.
- In bus-off, counts 128 occurrences of 11 consecutive recessive bits and signals recovery.

---
 rtl/can_pkg.sv | 18 +
 rtl/can_busoff_recovery.sv | 68 ++++++
 rtl/can_error_frame.sv | 200 ++++++++++++++++++++
 tb/tb_can_error_frame.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN controller types and default constants for the error-frame logic.
package can_pkg;

  // Error-frame sequencer states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLAG     = 3'd1,
    WAIT_REC = 3'd2,
    DELIM    = 3'd3,
    BUSOFF   = 3'd4
  } err_state_e;

  localparam int CAN_ERR_FLAG_LEN     = 6;
  localparam int CAN_ERR_DELIM_LEN    = 8;
  localparam int CAN_BUSOFF_IDLE_BITS = 11;
  localparam int CAN_BUSOFF_RECOVERY  = 128;

endpackage

// File: rtl/can_busoff_recovery.sv
// Bus-off recovery counter: counts runs of IDLE_BITS consecutive recessive
// samples and pulses recovery_done_o when RECOVERY_CNT runs have been seen.
// Both counters are held at zero whenever en_i is low.
module can_busoff_recovery
  import can_pkg::*;
#(
  parameter int IDLE_BITS    = CAN_BUSOFF_IDLE_BITS,
  parameter int RECOVERY_CNT = CAN_BUSOFF_RECOVERY
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic sample_point_i,
  input  logic rx_bit_i,
  output logic recovery_done_o
);

  localparam int RUN_W = $clog2(IDLE_BITS + 1);
  localparam int OCC_W = $clog2(RECOVERY_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(IDLE_BITS - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(RECOVERY_CNT);

  logic [RUN_W-1:0] run_q, run_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             done_q, done_d;

  // Next-state for run/occurrence counters; the occurrence count saturates
  // and is never cleared by a dominant bit, only by leaving bus-off.
  always_comb begin
    run_d  = run_q;
    occ_d  = occ_q;
    done_d = 1'b0;
    if (!en_i) begin
      run_d = '0;
      occ_d = '0;
    end else if (sample_point_i) begin
      if (!rx_bit_i) begin
        run_d = '0;
      end else if (run_q == RUN_LAST) begin
        run_d = '0;
        if (occ_q != OCC_MAX) begin
          occ_d = occ_q + 1'b1;
          if (occ_q == OCC_MAX - 1'b1) begin
            done_d = 1'b1;
          end
        end
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= '0;
      occ_q  <= '0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      occ_q  <= occ_d;
      done_q <= done_d;
    end
  end

  assign recovery_done_o = done_q;

endmodule

// File: rtl/can_error_frame.sv
// Error-frame generator and bus-off recovery sequencer. Drives the active or
// passive error flag plus delimiter, reports dominant bits after the flag,
// and sequences bus-off recovery through can_busoff_recovery.
module can_error_frame
  import can_pkg::*;
#(
  parameter int FLAG_LEN     = CAN_ERR_FLAG_LEN,
  parameter int DELIM_LEN    = CAN_ERR_DELIM_LEN,
  parameter int IDLE_BITS    = CAN_BUSOFF_IDLE_BITS,
  parameter int RECOVERY_CNT = CAN_BUSOFF_RECOVERY
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_point,
  input  logic rx_bit,
  input  logic error_detected,
  input  logic error_passive,
  input  logic bus_off,
  output logic err_tx_bit,
  output logic err_frame_active,
  output logic dominant_after_flag,
  output logic delim_form_error,
  output logic err_frame_done,
  output logic recovery_done
);

  localparam int FLAG_W  = $clog2(FLAG_LEN + 1);
  localparam int DELIM_W = $clog2(DELIM_LEN + 1);
  localparam logic [FLAG_W-1:0]  FLAG_FULL  = FLAG_W'(FLAG_LEN);
  localparam logic [DELIM_W-1:0] DELIM_LAST = DELIM_W'(DELIM_LEN - 1);

  err_state_e         state_q, state_d;
  logic               passive_q, passive_d;
  logic [FLAG_W-1:0]  flag_cnt_q, flag_cnt_d, flag_cnt_inc;
  logic               last_rx_q, last_rx_d;
  logic [2:0]         dom_cnt_q, dom_cnt_d;
  logic               first_q, first_d;
  logic [DELIM_W-1:0] delim_cnt_q, delim_cnt_d;
  logic               tx_q, tx_d;
  logic               active_q, active_d;
  logic               daf_q, daf_d;
  logic               form_err_q, form_err_d;
  logic               done_q, done_d;
  logic               enter_flag;
  logic               busoff_en;

  // Flag progress: active flags count bits; passive flags count consecutive
  // equal samples and restart at 1 on any polarity change.
  always_comb begin
    flag_cnt_inc = flag_cnt_q + 1'b1;
    if (passive_q && (flag_cnt_q != '0) && (rx_bit != last_rx_q)) begin
      flag_cnt_inc = FLAG_W'(1);
    end
  end

  // Next-state and output decode; bus_off overrides everything on any cycle.
  always_comb begin
    state_d     = state_q;
    passive_d   = passive_q;
    flag_cnt_d  = flag_cnt_q;
    last_rx_d   = last_rx_q;
    dom_cnt_d   = dom_cnt_q;
    first_d     = first_q;
    delim_cnt_d = delim_cnt_q;
    daf_d       = 1'b0;
    form_err_d  = 1'b0;
    done_d      = 1'b0;
    enter_flag  = 1'b0;

    if (bus_off) begin
      if (state_q != BUSOFF) begin
        state_d     = BUSOFF;
        passive_d   = 1'b0;
        flag_cnt_d  = '0;
        last_rx_d   = 1'b0;
        dom_cnt_d   = '0;
        first_d     = 1'b0;
        delim_cnt_d = '0;
      end
    end else if (sample_point) begin
      case (state_q)
        IDLE: begin
          if (error_detected) begin
            enter_flag = 1'b1;
          end
        end
        FLAG: begin
          last_rx_d = rx_bit;
          if (flag_cnt_inc == FLAG_FULL) begin
            state_d    = WAIT_REC;
            flag_cnt_d = '0;
            dom_cnt_d  = '0;
            first_d    = 1'b1;
          end else begin
            flag_cnt_d = flag_cnt_inc;
          end
        end
        WAIT_REC: begin
          first_d = 1'b0;
          if (rx_bit) begin
            state_d     = DELIM;
            delim_cnt_d = DELIM_W'(1);
            dom_cnt_d   = '0;
          end else begin
            // Wrap counter: every 8th consecutive dominant sample pulses.
            dom_cnt_d = dom_cnt_q + 1'b1;
            if ((first_q && !passive_q) || (dom_cnt_q == 3'd7)) begin
              daf_d = 1'b1;
            end
          end
        end
        DELIM: begin
          if (!rx_bit) begin
            form_err_d = 1'b1;
            enter_flag = 1'b1;
          end else if (error_detected) begin
            enter_flag = 1'b1;
          end else if (delim_cnt_q == DELIM_LAST) begin
            done_d      = 1'b1;
            state_d     = IDLE;
            delim_cnt_d = '0;
          end else begin
            delim_cnt_d = delim_cnt_q + 1'b1;
          end
        end
        BUSOFF: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (enter_flag) begin
        state_d     = FLAG;
        passive_d   = error_passive;
        flag_cnt_d  = '0;
        last_rx_d   = 1'b0;
        delim_cnt_d = '0;
      end
    end

    tx_d     = !((state_d == FLAG) && !passive_d);
    active_d = (state_d inside {FLAG, WAIT_REC, DELIM});
  end

  // State, counter and registered output updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      passive_q   <= 1'b0;
      flag_cnt_q  <= '0;
      last_rx_q   <= 1'b0;
      dom_cnt_q   <= '0;
      first_q     <= 1'b0;
      delim_cnt_q <= '0;
      tx_q        <= 1'b1;
      active_q    <= 1'b0;
      daf_q       <= 1'b0;
      form_err_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      passive_q   <= passive_d;
      flag_cnt_q  <= flag_cnt_d;
      last_rx_q   <= last_rx_d;
      dom_cnt_q   <= dom_cnt_d;
      first_q     <= first_d;
      delim_cnt_q <= delim_cnt_d;
      tx_q        <= tx_d;
      active_q    <= active_d;
      daf_q       <= daf_d;
      form_err_q  <= form_err_d;
      done_q      <= done_d;
    end
  end

  // Recovery counting only while bus-off is both entered and still asserted,
  // so the exit sample is never counted and an early drop clears progress.
  assign busoff_en = (state_q == BUSOFF) && bus_off;

  can_busoff_recovery #(
    .IDLE_BITS    (IDLE_BITS),
    .RECOVERY_CNT (RECOVERY_CNT)
  ) u_busoff_recovery (
    .clk             (clk),
    .rst             (rst),
    .en_i            (busoff_en),
    .sample_point_i  (sample_point),
    .rx_bit_i        (rx_bit),
    .recovery_done_o (recovery_done)
  );

  assign err_tx_bit          = tx_q;
  assign err_frame_active    = active_q;
  assign dominant_after_flag = daf_q;
  assign delim_form_error    = form_err_q;
  assign err_frame_done      = done_q;

endmodule

// File: tb/tb_can_error_frame.sv
// Self-checking bench for can_error_frame: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_can_error_frame;

  localparam int FLAG_LEN  = 6;
  localparam int DELIM_LEN = 8;
  localparam int IDLE_BITS = 11;
  localparam int RECOVERY  = 128;
  localparam int BIT_GAP   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_point = 1'b0;
  logic rx_bit = 1'b1;
  logic error_detected = 1'b0;
  logic error_passive = 1'b0;
  logic bus_off = 1'b0;
  logic err_tx_bit, err_frame_active, dominant_after_flag;
  logic delim_form_error, err_frame_done, recovery_done;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_stuck = 0;

  always #5 clk = ~clk;

  can_error_frame dut (
    .clk                 (clk),
    .rst                 (rst),
    .sample_point        (sample_point),
    .rx_bit              (rx_bit),
    .error_detected      (error_detected),
    .error_passive       (error_passive),
    .bus_off             (bus_off),
    .err_tx_bit          (err_tx_bit),
    .err_frame_active    (err_frame_active),
    .dominant_after_flag (dominant_after_flag),
    .delim_form_error    (delim_form_error),
    .err_frame_done      (err_frame_done),
    .recovery_done       (recovery_done)
  );

  // Output vector order: {tx, active, dom_after_flag, delim_form_err, done, recovery}
  function automatic logic [5:0] outs();
    return {err_tx_bit, err_frame_active, dominant_after_flag,
            delim_form_error, err_frame_done, recovery_done};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One bit time: sample strobe with the given inputs, capture outputs one
  // cycle later, then confirm pulses dropped after a single cycle.
  task automatic do_bit(input bit rx, input bit err, input bit pas, input bit bo,
                        output logic [5:0] got);
    @(negedge clk);
    rx_bit = rx; error_detected = err; error_passive = pas; bus_off = bo;
    sample_point = 1'b1;
    @(posedge clk); #1;
    got = outs();
    sample_point = 1'b0;
    error_detected = 1'b0;
    @(posedge clk); #1;
    if (outs() & 6'b001111) pulse_stuck++;
    repeat (BIT_GAP - 1) @(posedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int P_IDLE = 0, P_FLAG = 1, P_WAIT = 2, P_DELIM = 3, P_BOFF = 4;
  int m_phase, m_flag_bits, m_dom_run, m_delim, m_run, m_occ;
  bit m_passive, m_tx;
  bit flag_hist[$];

  function automatic void model_reset();
    m_phase = P_IDLE; m_flag_bits = 0; m_dom_run = 0; m_delim = 0;
    m_run = 0; m_occ = 0; m_passive = 0; m_tx = 1; flag_hist.delete();
  endfunction

  function automatic void model_start_flag(input bit pas);
    m_phase = P_FLAG; m_passive = pas; m_flag_bits = 0; flag_hist.delete();
  endfunction

  // Length of the run of equal samples at the end of the flag history.
  function automatic int trailing_run();
    int n = 0;
    for (int i = flag_hist.size() - 1; i >= 0; i--) begin
      if (flag_hist[i] != flag_hist[flag_hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [5:0] model_bit(input bit rx, input bit err, input bit pas, input bit bo);
    bit daf = 0, dfe = 0, done = 0, rec = 0, act;
    if (bo) begin
      if (m_phase != P_BOFF) begin
        m_phase = P_BOFF; m_run = 0; m_occ = 0;
      end else if (rx) begin
        m_run++;
        if (m_run == IDLE_BITS) begin
          m_run = 0;
          if (m_occ < RECOVERY) begin
            m_occ++;
            if (m_occ == RECOVERY) rec = 1;
          end
        end
      end else begin
        m_run = 0;
      end
    end else begin
      case (m_phase)
        P_IDLE: if (err) model_start_flag(pas);
        P_FLAG: begin
          flag_hist.push_back(rx);
          m_flag_bits++;
          if (m_passive ? (trailing_run() >= FLAG_LEN) : (m_flag_bits == FLAG_LEN)) begin
            m_phase = P_WAIT; m_dom_run = 0;
          end
        end
        P_WAIT: begin
          if (rx) begin
            m_phase = P_DELIM; m_delim = 1;
          end else begin
            m_dom_run++;
            if ((m_dom_run == 1 && !m_passive) || (m_dom_run % 8 == 0)) daf = 1;
          end
        end
        P_DELIM: begin
          if (!rx) begin
            dfe = 1; model_start_flag(pas);
          end else if (err) begin
            model_start_flag(pas);
          end else begin
            m_delim++;
            if (m_delim == DELIM_LEN) begin done = 1; m_phase = P_IDLE; end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    m_tx = !(m_phase == P_FLAG && !m_passive);
    act = (m_phase == P_FLAG || m_phase == P_WAIT || m_phase == P_DELIM);
    return {m_tx, act, daf, dfe, done, rec};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; sample_point = 1'b0; rx_bit = 1'b1; error_detected = 1'b0;
    error_passive = 1'b0; bus_off = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", outs(), 6'b100000);
    @(negedge clk) rst = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rx; bit err; bit pas; bit bo;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit rx, input bit err, input bit pas, input bit bo,
                              input logic [5:0] exp);
    vec_t v;
    v.rx = rx; v.err = err; v.pas = pas; v.bo = bo; v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [5:0] got;
    logic [5:0] exp;
    int first_rec, rec_count, bad, exp_rec;
    bit rx, err, pas, bo;

    // Active flag on an idle bus, then a passive flag with a polarity change.
    add(1, 1, 0, 0, 6'b010000);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 6'b010000);
    add(0, 0, 0, 0, 6'b110000);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 6'b110000);
    add(1, 0, 0, 0, 6'b100010);
    add(1, 1, 1, 0, 6'b110000);
    add(0, 0, 1, 0, 6'b110000);
    add(0, 0, 1, 0, 6'b110000);
    add(1, 1, 1, 0, 6'b110000);  // error strobe inside the flag is ignored
    for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 6'b110000);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 6'b110000);
    add(1, 0, 0, 0, 6'b100010);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      do_bit(tbl[i].rx, tbl[i].err, tbl[i].pas, tbl[i].bo, got);
      check($sformatf("vec[%0d]", i), got, tbl[i].exp);
      $display("vec %0d: rx=%0d err=%0d pas=%0d bo=%0d -> %b", i, tbl[i].rx, tbl[i].err,
               tbl[i].pas, tbl[i].bo, got);
    end

    // Dominant after flag: 17 dominant bits, pulses at post-flag bits 1, 8, 16.
    do_reset();
    do_bit(1, 1, 0, 0, got);
    for (int i = 1; i <= FLAG_LEN; i++) do_bit(0, 0, 0, 0, got);
    check("daf_flag_end", got, 6'b110000);
    for (int k = 1; k <= 17; k++) begin
      do_bit(0, 0, 0, 0, got);
      exp = {2'b11, (k == 1 || k == 8 || k == 16), 3'b000};
      check($sformatf("daf_bit%0d", k), got, exp);
    end
    for (int i = 1; i < DELIM_LEN; i++) do_bit(1, 0, 0, 0, got);
    check("daf_delim7", got, 6'b110000);
    do_bit(1, 0, 0, 0, got);
    check("daf_done", got, 6'b100010);
    $display("seq dominant_after_flag complete");

    // Delimiter form error at delimiter bit 4.
    do_reset();
    do_bit(1, 1, 0, 0, got);
    for (int i = 1; i <= FLAG_LEN; i++) do_bit(0, 0, 0, 0, got);
    bad = 0;
    for (int i = 1; i <= 3; i++) begin
      do_bit(1, 0, 0, 0, got);
      if (got !== 6'b110000) bad++;
    end
    check_int("dfe_delim_1_3", bad, 0);
    do_bit(0, 0, 0, 0, got);
    check("dfe_pulse", got, 6'b010100);
    for (int i = 1; i < FLAG_LEN; i++) do_bit(0, 0, 0, 0, got);
    check("dfe_flag2_bit6", got, 6'b010000);
    do_bit(0, 0, 0, 0, got);
    check("dfe_flag2_end", got, 6'b110000);
    for (int i = 1; i < DELIM_LEN; i++) do_bit(1, 0, 0, 0, got);
    check("dfe_delim7", got, 6'b110000);
    do_bit(1, 0, 0, 0, got);
    check("dfe_done", got, 6'b100010);
    $display("seq delim_form_error complete");

    // Bus-off recovery with one dominant bit at bit 500.
    do_reset();
    do_bit(1, 0, 0, 1, got);
    check("boff_entry", got, 6'b100000);
    first_rec = 0; rec_count = 0; bad = 0;
    for (int b = 1; b <= 1420; b++) begin
      do_bit((b == 500) ? 1'b0 : 1'b1, 0, 0, 1, got);
      if (got[0]) begin
        rec_count++;
        if (first_rec == 0) first_rec = b;
      end
      if (got[5:1] !== 5'b10000) bad++;
    end
    exp_rec = 500 + (RECOVERY - (499 / IDLE_BITS)) * IDLE_BITS;
    check_int("boff_rec_bit", first_rec, exp_rec);
    check_int("boff_rec_count", rec_count, 1);
    check_int("boff_outputs", bad, 0);
    do_bit(1, 0, 0, 0, got);
    check("boff_exit", got, 6'b100000);
    do_bit(1, 1, 0, 0, got);
    check("boff_idle_flag", got, 6'b010000);
    $display("seq busoff recovery at bit %0d", first_rec);

    // Bus-off dropped early clears progress.
    do_reset();
    do_bit(1, 0, 0, 1, got);
    rec_count = 0;
    for (int b = 1; b <= 600; b++) begin
      do_bit(1, 0, 0, 1, got);
      if (got[0]) rec_count++;
    end
    do_bit(1, 0, 0, 0, got);
    do_bit(1, 0, 0, 1, got);
    first_rec = 0;
    for (int b = 1; b <= 1410; b++) begin
      do_bit(1, 0, 0, 1, got);
      if (got[0]) begin
        rec_count++;
        if (first_rec == 0) first_rec = b;
      end
    end
    check_int("boff_drop_rec_bit", first_rec, RECOVERY * IDLE_BITS);
    check_int("boff_drop_rec_count", rec_count, 1);
    $display("seq busoff early drop complete");

    // Bus-off entry between sample points during a flag.
    do_reset();
    do_bit(1, 1, 0, 0, got);
    do_bit(0, 0, 0, 0, got);
    @(negedge clk) bus_off = 1'b1;
    @(posedge clk); #1;
    check("boff_async_entry", outs(), 6'b100000);
    $display("seq busoff async entry complete");

    // Reset asserted during flag bit 3.
    do_reset();
    do_bit(1, 1, 0, 0, got);
    do_bit(0, 0, 0, 0, got);
    do_bit(0, 0, 0, 0, got);
    check("rst_pre", got, 6'b010000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_flag", outs(), 6'b100000);
    @(negedge clk) rst = 1'b1;
    do_bit(1, 0, 0, 0, got);
    check("rst_idle_after", got, 6'b100000);
    $display("seq reset mid-flag complete");

    // Randomized stimulus against the behavioural model.
    do_reset();
    bo = 0; bad = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) bo = ~bo;
      rx  = m_tx ? ($urandom_range(0, 5) != 0) : 1'b0;
      err = ($urandom_range(0, 7) == 0);
      pas = $urandom_range(0, 1);
      exp = model_bit(rx, err, pas, bo);
      do_bit(rx, err, pas, bo, got);
      check($sformatf("rand[%0d]", i), got, exp);
    end
    $display("seq random 800 bits complete");

    check_int("pulse_width", pulse_stuck, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
